// File: rtl/line_buffer_scheduler_strided_pkg.sv
// Shared definitions for the strided 3x3 line-buffer scheduler.
package line_buffer_scheduler_strided_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sched_state_t;

  localparam int unsigned MAX_STRIDE = 2;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Only unit and double steps are supported by the window qualify logic.
  function automatic bit stride_legal(input int unsigned s);
    return (s >= 1) && (s <= MAX_STRIDE);
  endfunction

endpackage

// File: rtl/line_buffer_scheduler_strided_wrap_counter.sv
// Modulo counter with synchronous clear and enable. Clear restarts the
// sequence at index 0; an enable in the same cycle then steps from index 0.
module wrap_counter #(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] base;

  // Starting point for this cycle's step: zero when clearing.
  always_comb begin
    base = clr ? '0 : count;
    wrap = en && (base == LAST);
  end

  // Count register, advanced from the (possibly cleared) base.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || en) begin
      if (wrap) begin
        count <= '0;
      end else if (en) begin
        count <= base + WIDTH'(1);
      end else begin
        count <= base;
      end
    end
  end

endmodule

// File: rtl/line_buffer_scheduler_strided.sv
// Raster-position tracker for the 3x3 line buffer: flags each accepted
// pixel that completes a window on the stride grid, with window coordinates
// and an end-of-frame pulse, all registered one cycle after the pixel.
module line_buffer_scheduler_strided
  import line_buffer_scheduler_strided_pkg::*;
#(
  parameter int unsigned input_x = 4,
  parameter int unsigned input_y = 4,
  parameter int unsigned stride  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sof,
  input  logic                      input_valid,
  output logic                      output_valid,
  output logic [clog2(input_x)-1:0] out_row,
  output logic [clog2(input_y)-1:0] out_col,
  output logic                      eof,
  output logic                      busy
);

  localparam int unsigned WR   = clog2(input_x);
  localparam int unsigned WC   = clog2(input_y);
  localparam bit          STRIDE_OK = stride_legal(stride);
  localparam int unsigned STEP = STRIDE_OK ? stride : 1;
  localparam int unsigned WP   = clog2(STEP);

  sched_state_t state_q, state_d;

  // Row/column counters hold the position of the next expected pixel;
  // phase counters hold that position's offset from the stride grid.
  logic [WC-1:0] col_q;
  logic [WR-1:0] row_q;
  logic [WP-1:0] cph_q, rph_q;
  logic          col_wrap, row_wrap;
  logic          cph_wrap, rph_wrap;

  logic [WC-1:0] win_col_q;
  logic [WR-1:0] win_row_q;

  logic          start, accept;
  logic [WC-1:0] cur_col;
  logic [WR-1:0] cur_row;
  logic          col_in_win, row_in_win;
  logic          col_qual, row_qual, qualify;
  logic          row_step;

  logic unused_ok;
  assign unused_ok = &{1'b0, cph_wrap, rph_wrap};

  // Pixel acceptance and position of the pixel being loaded this cycle.
  always_comb begin
    start      = input_valid && sof;
    accept     = input_valid && (sof || (state_q == ACTIVE));
    cur_col    = start ? '0 : col_q;
    cur_row    = start ? '0 : row_q;
    col_in_win = cur_col >= WC'(2);
    row_in_win = cur_row >= WR'(2);
    col_qual   = col_in_win && (cph_q == '0);
    row_qual   = row_in_win && (rph_q == '0);
    qualify    = accept && col_qual && row_qual;
    row_step   = accept && col_wrap;
  end

  wrap_counter #(.MODULUS(input_y), .WIDTH(WC)) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (accept),
    .count (col_q),
    .wrap  (col_wrap)
  );

  // The row counter wraps only on the frame's last pixel, so its wrap flag
  // doubles as the end-of-frame detect.
  wrap_counter #(.MODULUS(input_x), .WIDTH(WR)) u_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (row_step),
    .count (row_q),
    .wrap  (row_wrap)
  );

  wrap_counter #(.MODULUS(STEP), .WIDTH(WP)) u_col_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept && (cur_col == WC'(1))),
    .en    (accept && col_in_win),
    .count (cph_q),
    .wrap  (cph_wrap)
  );

  wrap_counter #(.MODULUS(STEP), .WIDTH(WP)) u_row_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (row_step && (cur_row == WR'(1))),
    .en    (row_step && row_in_win),
    .count (rph_q),
    .wrap  (rph_wrap)
  );

  // Window coordinate counters: restart just before index 2, step per window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_col_q <= '0;
      win_row_q <= '0;
    end else begin
      if (accept && (cur_col == WC'(1))) begin
        win_col_q <= '0;
      end else if (qualify) begin
        win_col_q <= win_col_q + WC'(1);
      end
      if (row_step && (cur_row == WR'(1))) begin
        win_row_q <= '0;
      end else if (row_step && row_qual) begin
        win_row_q <= win_row_q + WR'(1);
      end
    end
  end

  // Registered window flags, aligned with the line buffer's updated window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_valid <= 1'b0;
      eof          <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      output_valid <= qualify;
      eof          <= row_wrap;
      if (qualify) begin
        out_row <= win_row_q;
        out_col <= win_col_q;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: sof always (re)starts a frame, the last pixel ends it.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == ACTIVE);
    if (start) begin
      state_d = ACTIVE;
    end else if (row_wrap) begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_line_buffer_scheduler_strided.sv
// Bench for the strided line-buffer scheduler: a 4x4/stride-1 and a
// 5x5/stride-2 instance share one stimulus stream and are each compared
// against a pixel-index reference model.
module tb_line_buffer_scheduler_strided;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sof = 1'b0;
  logic input_valid = 1'b0;

  logic       ova, eofa, busya;
  logic [1:0] rowa, cola;
  logic       ovb, eofb, busyb;
  logic [2:0] rowb, colb;

  line_buffer_scheduler_strided #(.input_x(4), .input_y(4), .stride(1)) u_a (
    .clk          (clk),
    .rst          (rst),
    .sof          (sof),
    .input_valid  (input_valid),
    .output_valid (ova),
    .out_row      (rowa),
    .out_col      (cola),
    .eof          (eofa),
    .busy         (busya)
  );

  line_buffer_scheduler_strided #(.input_x(5), .input_y(5), .stride(2)) u_b (
    .clk          (clk),
    .rst          (rst),
    .sof          (sof),
    .input_valid  (input_valid),
    .output_valid (ovb),
    .out_row      (rowb),
    .out_col      (colb),
    .eof          (eofb),
    .busy         (busyb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int mx[2] = '{4, 5};
  int my[2] = '{4, 5};
  int ms[2] = '{1, 2};

  bit m_active[2];
  int m_k[2];
  bit e_valid[2];
  bit e_eof[2];
  int e_row[2];
  int e_col[2];

  int win_cnt[2];
  int eof_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: frame position is a single pixel index k from the last sof.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit hit;
      int r, c;
      hit = 1'b0;
      e_valid[d] = 1'b0;
      e_eof[d]   = 1'b0;
      if (!rst) begin
        m_active[d] = 1'b0;
      end else if (input_valid) begin
        if (sof) begin
          m_k[d] = 0;
          m_active[d] = 1'b1;
          hit = 1'b1;
        end else if (m_active[d]) begin
          m_k[d] = m_k[d] + 1;
          hit = 1'b1;
        end
      end
      if (hit) begin
        r = m_k[d] / my[d];
        c = m_k[d] % my[d];
        if (r >= 2 && c >= 2 && (r - 2) % ms[d] == 0 && (c - 2) % ms[d] == 0) begin
          e_valid[d] = 1'b1;
          e_row[d] = (r - 2) / ms[d];
          e_col[d] = (c - 2) / ms[d];
        end
        if (m_k[d] == mx[d] * my[d] - 1) begin
          e_eof[d] = 1'b1;
          m_active[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("a_valid", ova, e_valid[0]);
    if (e_valid[0]) begin
      chk("a_row", rowa, e_row[0]);
      chk("a_col", cola, e_col[0]);
    end
    chk("a_eof", eofa, e_eof[0]);
    chk("a_busy", busya, m_active[0]);
    chk("b_valid", ovb, e_valid[1]);
    if (e_valid[1]) begin
      chk("b_row", rowb, e_row[1]);
      chk("b_col", colb, e_col[1]);
    end
    chk("b_eof", eofb, e_eof[1]);
    chk("b_busy", busyb, m_active[1]);
    if (ova === 1'b1) win_cnt[0]++;
    if (eofa === 1'b1) eof_cnt[0]++;
    if (ovb === 1'b1) win_cnt[1]++;
    if (eofb === 1'b1) eof_cnt[1]++;
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      e_valid[d]  = 1'b0;
      e_eof[d]    = 1'b0;
    end
    chk({tag, "_a_valid"}, ova, 0);
    chk({tag, "_a_eof"}, eofa, 0);
    chk({tag, "_a_busy"}, busya, 0);
    chk({tag, "_b_valid"}, ovb, 0);
    chk({tag, "_b_eof"}, eofb, 0);
    chk({tag, "_b_busy"}, busyb, 0);
  endtask

  task automatic drive(input bit s, input bit v);
    @(negedge clk);
    sof = s;
    input_valid = v;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      win_cnt[d] = 0;
      eof_cnt[d] = 0;
    end
  endtask

  initial begin
    bit s, v;

    // Power-on reset
    #12;
    check_reset("por");
    chk("por_a_row", rowa, 0);
    chk("por_a_col", cola, 0);
    chk("por_b_row", rowb, 0);
    chk("por_b_col", colb, 0);
    @(negedge clk);
    rst = 1'b1;

    // Pixels without sof are ignored
    clear_counts();
    repeat (10) drive(1'b0, 1'b1);
    chk("idle_win_a", win_cnt[0], 0);
    chk("idle_win_b", win_cnt[1], 0);

    // 4x4 stride 1, back-to-back
    clear_counts();
    drive(1'b1, 1'b1);
    repeat (15) drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    chk("s1_win_a", win_cnt[0], 4);
    chk("s1_eof_a", eof_cnt[0], 1);
    chk("s1_busy_a", busya, 0);

    // 4x4 with a gap after every pixel
    clear_counts();
    drive(1'b1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
    end
    repeat (2) drive(1'b0, 1'b0);
    chk("gap_win_a", win_cnt[0], 4);
    chk("gap_eof_a", eof_cnt[0], 1);

    // 5x5 stride 2
    clear_counts();
    drive(1'b1, 1'b1);
    repeat (24) drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    chk("s2_win_b", win_cnt[1], 4);
    chk("s2_eof_b", eof_cnt[1], 1);
    chk("s2_busy_b", busyb, 0);

    // Restart at pixel 7
    clear_counts();
    drive(1'b1, 1'b1);
    repeat (6) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (15) drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    chk("rs_win_a", win_cnt[0], 4);
    chk("rs_eof_a", eof_cnt[0], 1);

    // Random stream with sparse sof and gaps
    drive(1'b1, 1'b1);
    repeat (600) begin
      v = ($urandom % 4) != 0;
      s = v && (($urandom % 40) == 0);
      drive(s, v);
    end
    repeat (3) drive(1'b0, 1'b0);

    // Asynchronous reset mid-frame
    drive(1'b1, 1'b1);
    repeat (12) drive(1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset("arst");
    repeat (2) drive(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
    repeat (20) drive(1'b0, 1'b1);
    chk("post_rst_win_a", win_cnt[0], 0);
    chk("post_rst_win_b", win_cnt[1], 0);
    chk("post_rst_busy_a", busya, 0);
    drive(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_scheduler_strided.md
# line_buffer_scheduler_strided

Sequencer for the 3x3 sliding-window line buffer: tracks the raster position of every accepted pixel, decides which buffer states hold a complete window for a configurable stride (1 or 2, no padding), and flags them with `output_valid`, output coordinates and an end-of-frame pulse. Sits beside the line-buffer datapath, driven by the same `sof`/`input_valid` stream, and feeds the convolution engine's window-qualify logic.

## Interface
- `input_x`, default 4: frame height in rows; must be ≥3.
- `input_y`, default 4: row width in pixels; must equal the line buffer's `input_y`; must be ≥3.
- `stride`, default 1: window step, legal values 1 or 2.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sof`  in  1  start of frame; qualified by `input_valid`, marks pixel (0,0).
- `input_valid`  in  1  a pixel is loaded into the line buffer this cycle.
- `output_valid`  out  1  line-buffer window outputs hold a valid window this cycle.
- `out_row`  out  clog2(input_x)  window output row, valid with `output_valid`.
- `out_col`  out  clog2(input_y)  window output column, valid with `output_valid`.
- `eof`  out  1  one-cycle pulse coincident with the last window of the frame.
- `busy`  out  1  frame in progress (ACTIVE state).

## Operation
- States: IDLE, ACTIVE. Reset → IDLE; all outputs 0, counters 0.
- IDLE: `input_valid && !sof` ignored (no counting, no `output_valid`). `input_valid && sof` → ACTIVE; pixel counted as (r=0,c=0).
- ACTIVE: each `input_valid` advances c; c wraps input_y-1→0 and increments r. Gap cycles (`input_valid`=0) hold all counters.
- Window qualify for accepted pixel (r,c): r≥2, c≥2, (r-2) mod stride = 0, (c-2) mod stride = 0. Modulo implemented with phase counters reset at index 2, no divider.
- Output coords: out_row = (r-2)/stride, out_col = (c-2)/stride, maintained as incrementing counters stepped on each qualifying position.
- Last pixel (r=input_x-1, c=input_y-1) accepted → `eof` raised with its window (if qualifying; otherwise `eof` alone), state → IDLE.
- `sof && input_valid` while ACTIVE: frame restart; pixel is (0,0), counters cleared, no `eof` for the aborted frame, stays ACTIVE.
- Windows per frame: ((input_x-3)/stride+1)·((input_y-3)/stride+1); trailing rows/cols not reaching a stride point produce no output.

## Timing
- Latency: `output_valid`, `out_row`, `out_col`, `eof` registered; asserted the cycle after the edge that loaded the qualifying pixel (aligned with the line buffer's updated window).
- `output_valid` is a single-cycle pulse per window; back-to-back pixels yield back-to-back pulses for stride 1.
- `busy` rises the cycle after the `sof` edge, falls the cycle after the last-pixel edge (same cycle as `eof`).
- Async reset mid-frame: outputs drop immediately; next frame requires a fresh `sof`.
- No backpressure: the consumer must accept every `output_valid`.

## Structure
- Shared package: state encoding (IDLE/ACTIVE), `clog2` width function, stride legality check constant.
- One sub-module: `wrap_counter` (parameterised modulus, enable, sync clear, wrap flag), instanced for column, row, column phase and row phase.

## Test plan
- 4x4, stride 1, 16 back-to-back pixels after sof → `output_valid` after pixels 10,11,14,15, coords (0,0),(0,1),(1,0),(1,1); `eof` with pixel 15's window; `busy` low after.
- 5x5, stride 2, 25 pixels → 4 windows after pixels 12,14,22,24, coords (0,0),(0,1),(1,0),(1,1); `eof` with the last.
- 4x4 stride 1 with `input_valid` deasserted every other cycle → same 4 windows, each one cycle after its pixel; counters frozen in gaps.
- 10 pixels in IDLE without sof, then a normal frame → no output before sof; frame result identical to scenario 1.
- sof re-asserted at pixel 7 of a 4x4 frame → no `eof` for first frame; windows counted from the new (0,0).
- `rst` low at pixel 12 → `output_valid`, `busy`, `eof` 0 immediately; pixels after release without sof produce nothing.
